// File: rtl/arbitro_rr8_pkg.sv
// Shared types and constants for the 8-way round-robin arbiter.
package arb_pkg;

  localparam int N_REQ       = 8;
  localparam int PTR_W       = 3;
  localparam int CNT_W       = 8;
  localparam int TIMEOUT_DEF = 16;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_e;

  // Index of the set bit in a one-hot vector; zero vector maps to 0.
  function automatic logic [PTR_W-1:0] oh2idx(input logic [N_REQ-1:0] oh);
    logic [PTR_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (oh[i]) idx = idx | PTR_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/arbitro_rr8_if.sv
// Request/grant bundle between requesters (master) and the arbiter (slave).
interface arbitro_rr8_if;
  logic [arb_pkg::N_REQ-1:0] req;
  logic [arb_pkg::N_REQ-1:0] gnt;
  logic                      gnt_valid;
  logic                      to_pulse;

  modport master (output req, input gnt, gnt_valid, to_pulse);
  modport slave  (input req, output gnt, gnt_valid, to_pulse);
endinterface

// File: rtl/arbitro_rr8_rr_pick.sv
// Combinational rotating-priority picker: first set req bit at or above ptr,
// wrapping past 7 back to 0. Output is one-hot or zero.
module rr_pick
  import arb_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [PTR_W-1:0] ptr,
  output logic [N_REQ-1:0] pick
);

  always_comb begin
    logic             found;
    logic [PTR_W-1:0] idx;
    pick  = '0;
    found = 1'b0;
    idx   = '0;
    for (int k = 0; k < N_REQ; k++) begin
      // 3-bit add wraps modulo 8 on its own
      idx = ptr + PTR_W'(k);
      if (!found && req[idx]) begin
        pick[idx] = 1'b1;
        found     = 1'b1;
      end
    end
  end

endmodule

// File: rtl/arbitro_rr8.sv
// 8-way round-robin arbiter with hold-until-release grants.
// Define ARB_TIMEOUT_EN to force release after TIMEOUT busy cycles.
module arbitro_rr8
  import arb_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic         clk,
  input  logic         rst,
  arbitro_rr8_if.slave bus
);

  arb_state_e       state_q, state_d;
  logic [N_REQ-1:0] gnt_q, gnt_d;
  logic [N_REQ-1:0] pick;
  logic             gnt_valid_q, gnt_valid_d;
  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic             owner_req;
  logic             expire;

  if (TIMEOUT < 2 || TIMEOUT > 255) begin : g_bad_timeout
    $error("arbitro_rr8: TIMEOUT must be within 2..255");
  end

  rr_pick u_pick (
    .req  (bus.req),
    .ptr  (ptr_q),
    .pick (pick)
  );

`ifdef ARB_TIMEOUT_EN
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             to_q, to_d;

  // cnt_q counts completed busy cycles; the last one is TIMEOUT-1.
  assign expire = (state_q == BUSY) && (cnt_q == HOLD_LAST);

  always_comb begin
    cnt_d = '0;
    to_d  = expire;
    if (state_q == BUSY && !expire) cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
      to_q  <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      to_q  <= to_d;
    end
  end

  assign bus.to_pulse = to_q;
`else
  assign expire       = 1'b0;
  assign bus.to_pulse = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    ptr_d     = ptr_q;
    owner_req = |(bus.req & gnt_q);
    unique case (state_q)
      IDLE: begin
        if (|bus.req) begin
          gnt_d   = pick;
          state_d = BUSY;
        end
      end
      BUSY: begin
        // Release always passes through IDLE, giving one gnt=0 cycle.
        if (!owner_req || expire) begin
          gnt_d   = '0;
          state_d = IDLE;
          ptr_d   = oh2idx(gnt_q) + PTR_W'(1);
        end
      end
      default: begin
        gnt_d   = '0;
        state_d = IDLE;
      end
    endcase
    gnt_valid_d = |gnt_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      gnt_q       <= '0;
      gnt_valid_q <= 1'b0;
      ptr_q       <= '0;
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      gnt_valid_q <= gnt_valid_d;
      ptr_q       <= ptr_d;
    end
  end

  assign bus.gnt       = gnt_q;
  assign bus.gnt_valid = gnt_valid_q;

endmodule

// File: tb/tb_arbitro_rr8.sv
// Directed self-checking bench for arbitro_rr8 (TIMEOUT=4).
module tb_arbitro_rr8;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  arbitro_rr8_if bus ();

  arbitro_rr8 #(.TIMEOUT(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst     = 1'b1;
    bus.req = 8'h00;
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst     = 1'b1;
    bus.req = 8'hFF;
    step();
    step();
    total++;
    if (bus.gnt !== 8'h00 || bus.gnt_valid !== 1'b0 || bus.to_pulse !== 1'b0) begin
      $display("FAIL reset_state gnt=%b vld=%b to=%b exp gnt=00000000 vld=0 to=0",
               bus.gnt, bus.gnt_valid, bus.to_pulse);
      bad++;
    end
    rst     = 1'b0;
    bus.req = 8'h00;
    step();
    total++;
    if (bus.gnt !== 8'h00 || bus.gnt_valid !== 1'b0) begin
      $display("FAIL idle_noreq gnt=%b vld=%b exp 00000000/0", bus.gnt, bus.gnt_valid);
      bad++;
    end
  endtask

  task automatic test_basic();
    do_reset();
    bus.req = 8'b00000101;
    step();
    total++;
    if (bus.gnt !== 8'b00000001 || bus.gnt_valid !== 1'b1) begin
      $display("FAIL basic_first gnt=%b vld=%b exp 00000001/1", bus.gnt, bus.gnt_valid);
      bad++;
    end
    step();
    total++;
    if (bus.gnt !== 8'b00000001) begin
      $display("FAIL basic_hold gnt=%b exp 00000001", bus.gnt);
      bad++;
    end
    bus.req = 8'b00000100;
    step();
    total++;
    if (bus.gnt !== 8'h00 || bus.gnt_valid !== 1'b0) begin
      $display("FAIL basic_gap gnt=%b vld=%b exp 00000000/0", bus.gnt, bus.gnt_valid);
      bad++;
    end
    step();
    total++;
    if (bus.gnt !== 8'b00000100 || bus.gnt_valid !== 1'b1) begin
      $display("FAIL basic_second gnt=%b vld=%b exp 00000100/1", bus.gnt, bus.gnt_valid);
      bad++;
    end
    bus.req = 8'h00;
    step();
    step();
  endtask

  task automatic test_rotate();
    logic [7:0] cur;
    logic [7:0] nxt;
    do_reset();
    bus.req = 8'hFF;
    step();
    total++;
    if (bus.gnt !== 8'b00000001) begin
      $display("FAIL rot_start gnt=%b exp 00000001", bus.gnt);
      bad++;
    end
    for (int i = 0; i < 8; i++) begin
      cur = 8'(1 << i);
      nxt = 8'(1 << ((i + 1) % 8));
      bus.req = 8'hFF & ~cur;
      step();
      total++;
      if (bus.gnt !== 8'h00 || bus.gnt_valid !== 1'b0) begin
        $display("FAIL rot_gap%0d gnt=%b vld=%b exp 00000000/0", i, bus.gnt, bus.gnt_valid);
        bad++;
      end
      bus.req = 8'hFF;
      step();
      total++;
      if (bus.gnt !== nxt || bus.gnt_valid !== 1'b1) begin
        $display("FAIL rot_grant%0d gnt=%b vld=%b exp %b/1", i, bus.gnt, bus.gnt_valid, nxt);
        bad++;
      end
    end
  endtask

  task automatic test_wrap();
    do_reset();
    bus.req = 8'b10000000;
    step();
    total++;
    if (bus.gnt !== 8'b10000000) begin
      $display("FAIL wrap_own7 gnt=%b exp 10000000", bus.gnt);
      bad++;
    end
    bus.req = 8'b00000001;
    step();
    total++;
    if (bus.gnt !== 8'h00) begin
      $display("FAIL wrap_gap gnt=%b exp 00000000", bus.gnt);
      bad++;
    end
    bus.req = 8'b10000001;
    step();
    total++;
    if (bus.gnt !== 8'b00000001) begin
      $display("FAIL wrap_next gnt=%b exp 00000001", bus.gnt);
      bad++;
    end
  endtask

  task automatic test_no_preempt();
    do_reset();
    bus.req = 8'b00001000;
    step();
    total++;
    if (bus.gnt !== 8'b00001000) begin
      $display("FAIL np_own3 gnt=%b exp 00001000", bus.gnt);
      bad++;
    end
    bus.req = 8'b00101000;
    for (int i = 0; i < 3; i++) begin
      step();
      total++;
      if (bus.gnt !== 8'b00001000) begin
        $display("FAIL np_hold%0d gnt=%b exp 00001000", i, bus.gnt);
        bad++;
      end
    end
    bus.req = 8'b00100000;
    step();
    total++;
    if (bus.gnt !== 8'h00) begin
      $display("FAIL np_gap gnt=%b exp 00000000", bus.gnt);
      bad++;
    end
    step();
    total++;
    if (bus.gnt !== 8'b00100000) begin
      $display("FAIL np_own5 gnt=%b exp 00100000", bus.gnt);
      bad++;
    end
  endtask

  task automatic test_reset_mid();
    // Continues from test_no_preempt with owner 5 holding.
    #2;
    rst = 1'b1;
    #1;
    total++;
    if (bus.gnt !== 8'h00 || bus.gnt_valid !== 1'b0) begin
      $display("FAIL rst_async gnt=%b vld=%b exp 00000000/0", bus.gnt, bus.gnt_valid);
      bad++;
    end
    step();
    rst     = 1'b0;
    bus.req = 8'hFF;
    step();
    total++;
    if (bus.gnt !== 8'b00000001) begin
      $display("FAIL rst_reprio gnt=%b exp 00000001", bus.gnt);
      bad++;
    end
  endtask

  task automatic test_timeout();
    do_reset();
    bus.req = 8'b00000100;
    step();
    total++;
    if (bus.gnt !== 8'b00000100 || bus.to_pulse !== 1'b0) begin
      $display("FAIL to_grant gnt=%b to=%b exp 00000100/0", bus.gnt, bus.to_pulse);
      bad++;
    end
`ifdef ARB_TIMEOUT_EN
    for (int i = 0; i < 3; i++) begin
      step();
      total++;
      if (bus.gnt !== 8'b00000100 || bus.to_pulse !== 1'b0) begin
        $display("FAIL to_hold%0d gnt=%b to=%b exp 00000100/0", i, bus.gnt, bus.to_pulse);
        bad++;
      end
    end
    step();
    total++;
    if (bus.gnt !== 8'h00 || bus.gnt_valid !== 1'b0 || bus.to_pulse !== 1'b1) begin
      $display("FAIL to_fire gnt=%b vld=%b to=%b exp 00000000/0/1",
               bus.gnt, bus.gnt_valid, bus.to_pulse);
      bad++;
    end
    step();
    total++;
    if (bus.gnt !== 8'b00000100 || bus.to_pulse !== 1'b0) begin
      $display("FAIL to_regrant gnt=%b to=%b exp 00000100/0", bus.gnt, bus.to_pulse);
      bad++;
    end
`else
    for (int i = 0; i < 100; i++) begin
      step();
      total++;
      if (bus.gnt !== 8'b00000100 || bus.to_pulse !== 1'b0) begin
        $display("FAIL hold_forever%0d gnt=%b to=%b exp 00000100/0", i, bus.gnt, bus.to_pulse);
        bad++;
      end
    end
`endif
    bus.req = 8'h00;
    step();
  endtask

  initial begin
    total   = 0;
    bad     = 0;
    rst     = 1'b1;
    bus.req = 8'h00;
    test_reset();
    test_basic();
    test_rotate();
    test_wrap();
    test_no_preempt();
    test_reset_mid();
    test_timeout();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/arbitro_rr8.md
ARBITRO_RR8 -- requirements
Module: arbitro_rr8

Interface
REQ-001 Parameter TIMEOUT, default 16, maximum grant hold in cycles; legal range 2..255; used only when ARB_TIMEOUT_EN is defined.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 req  input  8  request lines; bit i is requester i, level-sensitive.
REQ-005 gnt  output 8  registered one-hot grant; all-zero when no owner; feeds the downstream 8-to-3 encoder directly.
REQ-006 gnt_valid  output 1  registered; 1 exactly when gnt is non-zero.
REQ-007 to_pulse  output 1  registered one-cycle timeout indication.

Function
REQ-008 States: IDLE (no owner) and BUSY (one owner holding gnt).
REQ-009 IDLE with req==0: stay IDLE; gnt=0, gnt_valid=0.
REQ-010 IDLE with req!=0: winner is the first set bit at or above ptr, searching ptr, ptr+1, ..., 7, 0, ..., ptr-1.
REQ-011 Grant latency is 1 cycle: the winner's gnt bit and gnt_valid are set on the edge that samples the request; state goes to BUSY.
REQ-012 gnt is always 0 or exactly one bit set; never two bits.
REQ-013 BUSY: gnt is held unchanged while req[owner]=1; other requests do not preempt.
REQ-014 BUSY with req[owner]=0 sampled: next edge clears gnt and gnt_valid, sets ptr=(owner+1) mod 8 (7 wraps to 0), and returns to IDLE.
REQ-015 Every release yields at least one cycle with gnt=0 before the next grant.
REQ-016 A requester that drops and raises req in one cycle is not re-granted until the IDLE cycle rearbitrates.
REQ-017 Requests asserted in the release cycle are arbitrated in the following IDLE cycle with the updated ptr.
REQ-018 to_pulse is 0 except as in REQ-023.

Reset
REQ-019 rst=1 immediately forces gnt=0, gnt_valid=0, to_pulse=0, state=IDLE, ptr=0, hold counter=0, including in the middle of a grant.
REQ-020 First arbitration after reset release gives priority to req[0].

Configuration
REQ-021 Macro ARB_TIMEOUT_EN selects the hold timeout.
REQ-022 With ARB_TIMEOUT_EN: a hold counter clears on grant and increments every BUSY cycle.
REQ-023 With ARB_TIMEOUT_EN: when the grant has been asserted for TIMEOUT cycles, the next edge releases as in REQ-014 regardless of req[owner], and to_pulse=1 for that one cycle.
REQ-024 Without ARB_TIMEOUT_EN: no counter exists, to_pulse is tied 0, and grants are held indefinitely.

Structure
REQ-025 Shared package arb_pkg holds the state typedef (IDLE, BUSY), constant N_REQ=8, and constant TIMEOUT_DEF=16.
REQ-026 Sub-module rr_pick is the combinational rotating-priority picker: inputs req[7:0] and ptr[2:0], output one-hot pick[7:0].
REQ-027 ptr is 3 bits; wrap is natural modulo-8 overflow.

Verification
REQ-028 Reset, then req=8'b00000101 held -> gnt=8'b00000001 one cycle later; drop req[0] -> gnt=0 for 1 cycle, then gnt=8'b00000100.
REQ-029 req=8'hFF held, each owner drops then re-raises after its release -> grant order 0,1,...,7,0 with one gnt=0 cycle between grants.
REQ-030 Owner 7 releases while req=8'b10000001 -> ptr wraps to 0 and the next gnt is 8'b00000001.
REQ-031 Owner 3 is granted, then req[5] rises -> gnt stays 8'b00001000 until req[3] falls.
REQ-032 rst pulsed while gnt=8'b00100000 -> gnt=0 before the next edge; after release, req=8'hFF -> gnt=8'b00000001.
REQ-033 With ARB_TIMEOUT_EN and TIMEOUT=4, req[2] held -> gnt[2] high exactly 4 cycles, then to_pulse=1 and gnt=0 for one cycle; without the macro, gnt[2] is held for 100 cycles and to_pulse stays 0.
